// File: rtl/vscale_htif_pcr_arbiter.sv
// Round-robin arbiter sharing the single vscale HTIF PCR port among NREQ requesters, one transaction in flight.
// Optional response watchdog is enabled by defining VSCALE_PCR_ARB_TIMEOUT_EN.
`ifndef HTIF_PCR_WIDTH
`define HTIF_PCR_WIDTH 64
`endif

module vscale_htif_pcr_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 12,
    parameter int DATA_W = `HTIF_PCR_WIDTH
`ifdef VSCALE_PCR_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_rw,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          resp_valid,
    input  logic [NREQ-1:0]          resp_ready,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_err,
    output logic                     htif_pcr_req_valid,
    input  logic                     htif_pcr_req_ready,
    output logic                     htif_pcr_req_rw,
    output logic [ADDR_W-1:0]        htif_pcr_req_addr,
    output logic [DATA_W-1:0]        htif_pcr_req_data,
    input  logic                     htif_pcr_resp_valid,
    output logic                     htif_pcr_resp_ready,
    input  logic [DATA_W-1:0]        htif_pcr_resp_data
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

    state_t              state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    owner;
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_found;
    logic                sel_rw;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                lat_rw;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_data;
    logic                owner_done;

`ifdef VSCALE_PCR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    wait_cnt;
    logic                err_q;
`endif

    // NOTE: every output of an always_comb block gets a default first, so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        // Rotating priority: indices at or above rr_ptr first, then wrap to the low indices.
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i] && (i >= int'(rr_ptr))) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(i);
            end
        end
    end

    always_comb begin
        sel_rw   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(grant_idx) == i) begin
                sel_rw   = req_rw[i];
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // req_ready is gated by reset so no grant is offered while the state is being cleared.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i]  = !reset && (state == S_IDLE) && grant_found && (int'(grant_idx) == i);
            resp_valid[i] = (state == S_DELIVER) && (int'(owner) == i);
        end
    end

    assign owner_done          = |(resp_valid & resp_ready);
    assign htif_pcr_req_valid  = (state == S_ISSUE);
    assign htif_pcr_req_rw     = lat_rw;
    assign htif_pcr_req_addr   = lat_addr;
    assign htif_pcr_req_data   = lat_data;
    assign htif_pcr_resp_ready = (state == S_WAIT);

`ifdef VSCALE_PCR_ARB_TIMEOUT_EN
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            resp_data <= '0;
`ifdef VSCALE_PCR_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        owner    <= grant_idx;
                        lat_rw   <= sel_rw;
                        lat_addr <= sel_addr;
                        lat_data <= sel_data;
                        rr_ptr   <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (htif_pcr_req_ready) begin
                        state <= S_WAIT;
`ifdef VSCALE_PCR_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (htif_pcr_resp_valid) begin
                        resp_data <= htif_pcr_resp_data;
                        state     <= S_DELIVER;
`ifdef VSCALE_PCR_ARB_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (int'(wait_cnt) == TIMEOUT_CYCLES - 1) begin
                        resp_data <= '0;
                        err_q     <= 1'b1;
                        state     <= S_DELIVER;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_DELIVER: begin
                    if (owner_done) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Self-checking bench for vscale_htif_pcr_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin model. Timeout scenario runs when VSCALE_PCR_ARB_TIMEOUT_EN is defined.
module tb_vscale_htif_pcr_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_rw;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        resp_valid;
    logic [NREQ-1:0]        resp_ready;
    logic [DATA_W-1:0]      resp_data;
    logic                   resp_err;
    logic                   htif_pcr_req_valid;
    logic                   htif_pcr_req_ready;
    logic                   htif_pcr_req_rw;
    logic [ADDR_W-1:0]      htif_pcr_req_addr;
    logic [DATA_W-1:0]      htif_pcr_req_data;
    logic                   htif_pcr_resp_valid;
    logic                   htif_pcr_resp_ready;
    logic [DATA_W-1:0]      htif_pcr_resp_data;

    int errors = 0;
    int checks = 0;

    // Transaction-level model state for the randomized phase.
    bit                m_pend [NREQ];
    bit                m_rw   [NREQ];
    logic [ADDR_W-1:0] m_addr [NREQ];
    logic [DATA_W-1:0] m_data [NREQ];
    int                rr_m;
    bit                busy, issued, responded;
    int                own;
    bit                g_rw;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    logic [DATA_W-1:0] exp_resp;
    int                txns;
    int                win;

    vscale_htif_pcr_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_rw              (req_rw),
        .req_addr            (req_addr),
        .req_data            (req_data),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_data           (resp_data),
        .resp_err            (resp_err),
        .htif_pcr_req_valid  (htif_pcr_req_valid),
        .htif_pcr_req_ready  (htif_pcr_req_ready),
        .htif_pcr_req_rw     (htif_pcr_req_rw),
        .htif_pcr_req_addr   (htif_pcr_req_addr),
        .htif_pcr_req_data   (htif_pcr_req_data),
        .htif_pcr_resp_valid (htif_pcr_resp_valid),
        .htif_pcr_resp_ready (htif_pcr_resp_ready),
        .htif_pcr_resp_data  (htif_pcr_resp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input bit rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_rw[i] = rw;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First pending requester scanning rr_m, rr_m+1, ... modulo NREQ; -1 when none.
    function automatic int rr_pick();
        for (int k = 0; k < NREQ; k++) begin
            if (m_pend[(rr_m + k) % NREQ]) return (rr_m + k) % NREQ;
        end
        return -1;
    endfunction

    initial begin
        int ngr, last_c, wcnt;
        bit done;

        reset = 1'b1;
        req_valid = '1; req_rw = '0; req_addr = '0; req_data = '0; resp_ready = '0;
        htif_pcr_req_ready = 1'b0; htif_pcr_resp_valid = 1'b0; htif_pcr_resp_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, '0);
        check("rst_resp_valid", resp_valid, '0);
        check("rst_htif_req_valid", htif_pcr_req_valid, 0);
        check("rst_htif_resp_ready", htif_pcr_resp_ready, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        req_valid = '0;
        reset = 1'b0;

        // 1: single read of tohost, zero-wait downstream
        tick();
        req_valid = 3'b001; set_req(0, 1'b0, 12'h780, '0);
        resp_ready = '1; htif_pcr_req_ready = 1'b1;
        #1 check("t1_grant", req_ready, 3'b001);
        tick();
        req_valid = '0;
        #1;
        check("t1_htif_valid", htif_pcr_req_valid, 1);
        check("t1_htif_addr", htif_pcr_req_addr, 12'h780);
        check("t1_htif_rw", htif_pcr_req_rw, 0);
        check("t1_no_ready", req_ready, '0);
        tick();
        htif_pcr_resp_valid = 1'b1; htif_pcr_resp_data = 64'd144;
        #1 check("t1_htif_resp_ready", htif_pcr_resp_ready, 1);
        tick();
        htif_pcr_resp_valid = 1'b0;
        #1;
        check("t1_resp_valid", resp_valid, 3'b001);
        check("t1_resp_data", resp_data, 64'd144);
        check("t1_resp_err", resp_err, 0);
        tick();
        #1 check("t1_resp_done", resp_valid, '0);

        // 2: two requesters held valid alternate, one grant every 4 cycles
        do_reset();
        req_valid = 3'b011; htif_pcr_req_ready = 1'b1;
        htif_pcr_resp_valid = 1'b1; htif_pcr_resp_data = 64'h77;
        ngr = 0; last_c = 0;
        for (int c = 0; c < 60 && ngr < 8; c++) begin
            #1;
            if (req_ready != '0) begin
                check("t2_order", req_ready, onehot(ngr % 2));
                if (ngr > 0) check("t2_spacing", c - last_c, 4);
                last_c = c;
                ngr++;
            end
            tick();
        end
        check("t2_count", ngr, 8);
        req_valid = '0; htif_pcr_req_ready = 1'b0; htif_pcr_resp_valid = 1'b0;

        // 3: downstream stalls in ISSUE, request fields stay latched
        do_reset();
        req_valid = 3'b100; req_rw = 3'b100;
        set_req(2, 1'b1, 12'h123, 64'hDEAD_BEEF_0123_4567);
        #1 check("t3_grant", req_ready, 3'b100);
        tick();
        req_valid = '0; req_rw = '0; set_req(2, 1'b0, 12'hFFF, '1);
        for (int s = 0; s < 5; s++) begin
            #1;
            check("t3_stall_valid", htif_pcr_req_valid, 1);
            check("t3_stall_rw", htif_pcr_req_rw, 1);
            check("t3_stall_addr", htif_pcr_req_addr, 12'h123);
            check("t3_stall_data", htif_pcr_req_data, 64'hDEAD_BEEF_0123_4567);
            tick();
        end
        htif_pcr_req_ready = 1'b1;
        #1 check("t3_issue_valid", htif_pcr_req_valid, 1);
        tick();
        htif_pcr_req_ready = 1'b0;
        #1;
        check("t3_wait_resp_ready", htif_pcr_resp_ready, 1);
        check("t3_wait_req_valid", htif_pcr_req_valid, 0);

        // 4: owner back-pressures the response
        htif_pcr_resp_valid = 1'b1; htif_pcr_resp_data = 64'h5555_AAAA_1234_0042;
        tick();
        htif_pcr_resp_valid = 1'b0; htif_pcr_resp_data = '0;
        resp_ready = '0; req_valid = 3'b011;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("t4_hold_valid", resp_valid, 3'b100);
            check("t4_hold_data", resp_data, 64'h5555_AAAA_1234_0042);
            check("t4_no_grant", req_ready, '0);
            tick();
        end
        resp_ready = 3'b100;
        #1 check("t4_deliver", resp_valid, 3'b100);
        tick();
        resp_ready = '1;
        #1 check("t4_next_grant", req_ready, 3'b001);

        // 5: reset in WAIT clears outputs without a clock edge
        tick();
        req_valid = '0; htif_pcr_req_ready = 1'b1;
        #1 check("t5_issue", htif_pcr_req_valid, 1);
        tick();
        htif_pcr_req_ready = 1'b0;
        #1 check("t5_in_wait", htif_pcr_resp_ready, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_resp_ready", htif_pcr_resp_ready, 0);
        check("t5_rst_req_valid", htif_pcr_req_valid, 0);
        check("t5_rst_resp_valid", resp_valid, '0);
        check("t5_rst_resp_data", resp_data, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        req_valid = 3'b010;
        #1 check("t5_req1_grant", req_ready, 3'b010);
        req_valid = '0;
        do_reset();
        req_valid = 3'b111;
        #1 check("t5_rr_cleared", req_ready, 3'b001);
        req_valid = '0;

`ifdef VSCALE_PCR_ARB_TIMEOUT_EN
        // 6: watchdog fires after 256 WAIT cycles; a response on the last cycle wins
        resp_ready = '1;
        do_reset();
        req_valid = 3'b001; set_req(0, 1'b0, 12'h780, '0);
        #1 check("t6_grant", req_ready, 3'b001);
        tick();
        req_valid = '0; htif_pcr_req_ready = 1'b1;
        tick();
        htif_pcr_req_ready = 1'b0;
        wcnt = 0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            #1;
            if (resp_valid != '0) begin
                done = 1'b1;
            end else begin
                if (htif_pcr_resp_ready) wcnt++;
                tick();
            end
        end
        check("t6_timeout_seen", done, 1);
        check("t6_wait_cycles", wcnt, 256);
        check("t6_to_valid", resp_valid, 3'b001);
        check("t6_to_err", resp_err, 1);
        check("t6_to_data", resp_data, 0);
        check("t6_late_dropped", htif_pcr_resp_ready, 0);
        do_reset();
        req_valid = 3'b001;
        tick();
        req_valid = '0; htif_pcr_req_ready = 1'b1;
        tick();
        htif_pcr_req_ready = 1'b0;
        for (int w = 1; w <= 256; w++) begin
            if (w == 256) begin
                htif_pcr_resp_valid = 1'b1; htif_pcr_resp_data = 64'h0BAD_F00D_0000_0090;
            end
            #1;
            if (w == 256) check("t6_last_wait", htif_pcr_resp_ready, 1);
            tick();
        end
        htif_pcr_resp_valid = 1'b0;
        #1;
        check("t6_win_valid", resp_valid, 3'b001);
        check("t6_win_err", resp_err, 0);
        check("t6_win_data", resp_data, 64'h0BAD_F00D_0000_0090);
`endif

        // Randomized traffic against the transaction-level model
        req_valid = '0; resp_ready = '0; htif_pcr_req_ready = 1'b0; htif_pcr_resp_valid = 1'b0;
        do_reset();
        for (int i = 0; i < NREQ; i++) m_pend[i] = 1'b0;
        rr_m = 0; busy = 1'b0; issued = 1'b0; responded = 1'b0; own = 0; txns = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!m_pend[i] && $urandom_range(0, 2) == 0) begin
                    m_pend[i] = 1'b1;
                    m_rw[i]   = 1'($urandom_range(0, 1));
                    m_addr[i] = ADDR_W'($urandom);
                    m_data[i] = {$urandom, $urandom};
                end
                req_valid[i] = m_pend[i];
                if (m_pend[i]) set_req(i, m_rw[i], m_addr[i], m_data[i]);
                else set_req(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom), {$urandom, $urandom});
                resp_ready[i] = ($urandom_range(0, 2) != 0);
            end
            htif_pcr_req_ready  = ($urandom_range(0, 2) != 0);
            htif_pcr_resp_valid = ($urandom_range(0, 1) != 0);
            htif_pcr_resp_data  = {$urandom, $urandom};
            #1;
            win = busy ? -1 : rr_pick();
            check("rnd_req_ready", req_ready, (win >= 0) ? onehot(win) : '0);
            check("rnd_htif_req_valid", htif_pcr_req_valid, busy && !issued);
            if (busy && !issued) begin
                check("rnd_htif_rw", htif_pcr_req_rw, g_rw);
                check("rnd_htif_addr", htif_pcr_req_addr, g_addr);
                check("rnd_htif_data", htif_pcr_req_data, g_data);
            end
            check("rnd_htif_resp_ready", htif_pcr_resp_ready, busy && issued && !responded);
            check("rnd_resp_valid", resp_valid, (busy && responded) ? onehot(own) : '0);
            if (busy && responded) begin
                check("rnd_resp_data", resp_data, exp_resp);
                check("rnd_resp_err", resp_err, 0);
            end
            if (!busy) begin
                if (win >= 0) begin
                    busy = 1'b1; issued = 1'b0; responded = 1'b0; own = win;
                    g_rw = m_rw[win]; g_addr = m_addr[win]; g_data = m_data[win];
                    m_pend[win] = 1'b0;
                    rr_m = (win + 1) % NREQ;
                end
            end else if (!issued) begin
                if (htif_pcr_req_ready) issued = 1'b1;
            end else if (!responded) begin
                if (htif_pcr_resp_valid) begin
                    responded = 1'b1;
                    exp_resp = htif_pcr_resp_data;
                end
            end else if (resp_ready[own]) begin
                busy = 1'b0;
                txns++;
            end
            tick();
        end
        check("rnd_progress", txns > 40, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
